btn_event_ctrl: RTL and testbench

- Sits between the per-button btn_debouncer instances and the game logic.
- Turns NUM_BTNS debounced button levels into a single serialized event stream with a valid/ready handshake.
- Per-button FSM generates an initial-press event, then auto-repeat events after a hold delay.
- Round-robin arbiter shares the single event output between buttons.

---
 rtl/btn_event_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_ctrl.sv
// Debounced button levels -> serialized press / auto-repeat event stream (valid/ready).
// Define BTN_REPEAT_EN to build the hold/auto-repeat timers; otherwise only press events are produced.
module btn_event_ctrl #(
    parameter int   NUM_BTNS      = 4,
    parameter int   CLKIN_FREQ    = 27000000,
    parameter real  HOLD_DELAY    = 0.5,
    parameter real  REPEAT_PERIOD = 0.1,
    parameter logic IDLE_STATE    = 1'b1,
    localparam int  BTN_W         = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btnLevel,
    output logic                eventValid,
    input  logic                eventReady,
    output logic [BTN_W-1:0]    eventBtn,
    output logic                eventRepeat,
    output logic [NUM_BTNS-1:0] pendingMask,
    output logic                eventDropped
);

    genvar gi;

    if (NUM_BTNS < 1 || NUM_BTNS > 16 || CLKIN_FREQ < 1 ||
        HOLD_DELAY < 0.0 || REPEAT_PERIOD < 0.0) begin : g_param_check
        $error("btn_event_ctrl: parameter out of range");
    end

`ifdef BTN_REPEAT_EN
    localparam int HOLD_RAW      = $rtoi(real'(CLKIN_FREQ) * HOLD_DELAY);
    localparam int REPEAT_RAW    = $rtoi(real'(CLKIN_FREQ) * REPEAT_PERIOD);
    localparam int HOLD_CYCLES   = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
    localparam int REPEAT_CYCLES = (REPEAT_RAW < 1) ? 1 : REPEAT_RAW;
    localparam int CNT_MAX       = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;
`else
    typedef enum logic {ST_IDLE, ST_HELD} state_t;
`endif

    logic [NUM_BTNS-1:0] pressed;
    logic [NUM_BTNS-1:0] ev_vec;
    logic [NUM_BTNS-1:0] ev_kind_vec;

    assign pressed = btnLevel ^ {NUM_BTNS{IDLE_STATE}};

    // Per-button FSM; event pulses are registered so pending lags the sampled press by one cycle.
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        state_t state_reg;
        logic   ev_reg;
        logic   kind_reg;

        assign ev_vec[gi]      = ev_reg;
        assign ev_kind_vec[gi] = kind_reg;

`ifdef BTN_REPEAT_EN
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (!reset) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                ev_reg    <= 1'b0;
                kind_reg  <= 1'b0;
            end else begin
                ev_reg   <= 1'b0;
                kind_reg <= 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (pressed[gi]) begin
                            state_reg <= ST_HELD;
                            cnt_reg   <= HOLD_LOAD;
                            ev_reg    <= 1'b1;
                        end
                    end
                    ST_HELD, ST_REPEAT: begin
                        if (!pressed[gi]) begin
                            state_reg <= ST_IDLE;
                        end else if (cnt_reg == '0) begin
                            state_reg <= ST_REPEAT;
                            cnt_reg   <= REPEAT_LOAD;
                            ev_reg    <= 1'b1;
                            kind_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
`else
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_reg <= ST_IDLE;
                ev_reg    <= 1'b0;
                kind_reg  <= 1'b0;
            end else begin
                ev_reg   <= 1'b0;
                kind_reg <= 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (pressed[gi]) begin
                            state_reg <= ST_HELD;
                            ev_reg    <= 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!pressed[gi]) state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
`endif
    end

    logic [NUM_BTNS-1:0] pend_reg;
    logic [NUM_BTNS-1:0] pend_kind_reg;
    logic [BTN_W-1:0]    ptr_reg;
    logic                valid_reg;
    logic [BTN_W-1:0]    btn_reg;
    logic                rpt_reg;
    logic                drop_reg;

    logic                load_en;
    logic                grant_any;
    logic [BTN_W-1:0]    grant_idx;
    logic                grant_kind;
    logic [NUM_BTNS-1:0] grant_vec;
    logic [NUM_BTNS-1:0] take_kind;
    logic [BTN_W-1:0]    ptr_next;

    assign load_en = !valid_reg || eventReady;

    // Round-robin: scan from the pointer upward, then wrap and scan from 0.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_kind = 1'b0;
        grant_vec  = '0;
        for (int j = 0; j < NUM_BTNS; j++) begin
            if (!grant_any && pend_reg[j] && (j >= int'(ptr_reg))) begin
                grant_any  = 1'b1;
                grant_idx  = BTN_W'(j);
                grant_kind = pend_kind_reg[j];
            end
        end
        for (int j = 0; j < NUM_BTNS; j++) begin
            if (!grant_any && pend_reg[j]) begin
                grant_any  = 1'b1;
                grant_idx  = BTN_W'(j);
                grant_kind = pend_kind_reg[j];
            end
        end
        for (int j = 0; j < NUM_BTNS; j++) begin
            grant_vec[j] = load_en && grant_any && (int'(grant_idx) == j);
        end
    end

    assign ptr_next  = (int'(grant_idx) == NUM_BTNS - 1) ? '0 : grant_idx + 1'b1;
    // A new event takes its own kind unless it merges into an older pending one.
    assign take_kind = ev_vec & (~pend_reg | grant_vec);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_reg      <= '0;
            pend_kind_reg <= '0;
            ptr_reg       <= '0;
            valid_reg     <= 1'b0;
            btn_reg       <= '0;
            rpt_reg       <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            pend_reg      <= (pend_reg & ~grant_vec) | ev_vec;
            pend_kind_reg <= (pend_kind_reg & ~take_kind) | (ev_kind_vec & take_kind);
            drop_reg      <= |(ev_vec & pend_reg & ~grant_vec);
            if (load_en) begin
                valid_reg <= grant_any;
                if (grant_any) begin
                    btn_reg <= grant_idx;
                    rpt_reg <= grant_kind;
                    ptr_reg <= ptr_next;
                end
            end
        end
    end

    assign eventValid   = valid_reg;
    assign eventBtn     = btn_reg;
    assign eventRepeat  = rpt_reg;
    assign pendingMask  = pend_reg;
    assign eventDropped = drop_reg;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: reset, press/repeat timing, arbitration, backpressure, reset mid-flight.
module tb_btn_event_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btnLevel;
    logic          eventReady;
    logic          eventValid;
    logic [1:0]    eventBtn;
    logic          eventRepeat;
    logic [NB-1:0] pendingMask;
    logic          eventDropped;

    always #5 clk = ~clk;

    btn_event_ctrl #(
        .NUM_BTNS(NB),
        .CLKIN_FREQ(1000),
        .HOLD_DELAY(0.01),
        .REPEAT_PERIOD(0.004),
        .IDLE_STATE(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btnLevel(btnLevel),
        .eventValid(eventValid),
        .eventReady(eventReady),
        .eventBtn(eventBtn),
        .eventRepeat(eventRepeat),
        .pendingMask(pendingMask),
        .eventDropped(eventDropped)
    );

    typedef struct {
        int stamp;
        int btn;
        int rpt;
    } evt_t;

    evt_t evq[$];
    int   cyc      = 0;
    int   drop_cnt = 0;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   c0       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted handshakes are logged with the edge count at which they became visible.
    always @(negedge clk) begin
        if (reset === 1'b1 && eventValid === 1'b1 && eventReady === 1'b1) begin
            evq.push_back('{stamp: cyc, btn: int'(eventBtn), rpt: int'(eventRepeat)});
            $display("event cyc=%0d btn=%0d repeat=%0d", cyc, eventBtn, eventRepeat);
        end
        if (reset === 1'b1 && eventDropped === 1'b1) drop_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_evt(input string tag, input int idx, input int off, input int btn, input int rpt);
        if (idx < evq.size()) begin
            check_eq({tag, "_time"}, evq[idx].stamp - c0, off);
            check_eq({tag, "_btn"}, evq[idx].btn, btn);
            check_eq({tag, "_rpt"}, evq[idx].rpt, rpt);
        end else begin
            check_eq({tag, "_missing"}, evq.size(), idx + 1);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        btnLevel   = '1;
        eventReady = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);
        evq.delete();
        drop_cnt = 0;
    endtask

    initial begin
        logic [NB-1:0] arb_mask [4];
        arb_mask[0] = 4'b1110;
        arb_mask[1] = 4'b1100;
        arb_mask[2] = 4'b1000;
        arb_mask[3] = 4'b0000;

        // Reset with all buttons released
        reset      = 1'b0;
        btnLevel   = 4'b1111;
        eventReady = 1'b1;
        tick(5);
        check_eq("rst_valid", int'(eventValid), 0);
        check_eq("rst_btn", int'(eventBtn), 0);
        check_eq("rst_repeat", int'(eventRepeat), 0);
        check_eq("rst_pending", int'(pendingMask), 0);
        check_eq("rst_dropped", int'(eventDropped), 0);
        reset = 1'b1;
        tick(10);
        check_eq("rst_no_events", evq.size(), 0);
        check_eq("rst_pending_after", int'(pendingMask), 0);

        // Single press held 30 cycles on button 2
        evq.delete();
        c0 = cyc;
        btnLevel[2] = 1'b0;
        tick(30);
        btnLevel[2] = 1'b1;
        tick(20);
`ifdef BTN_REPEAT_EN
        check_eq("press_count", evq.size(), 6);
        check_evt("press0", 0, 3, 2, 0);
        for (int k = 0; k < 5; k++) begin
            check_evt($sformatf("repeat%0d", k), k + 1, 13 + 4 * k, 2, 1);
        end
`else
        check_eq("press_count", evq.size(), 1);
        check_evt("press0", 0, 3, 2, 0);
`endif

        // Arbitration: all four pressed in one cycle
        do_reset();
        c0 = cyc;
        btnLevel = 4'b0000;
        tick(1);
        btnLevel = 4'b1111;
        tick(1);
        check_eq("arb_pend_all", int'(pendingMask), 15);
        check_eq("arb_valid_pre", int'(eventValid), 0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check_eq($sformatf("arb%0d_pend", k), int'(pendingMask), int'(arb_mask[k]));
            check_eq($sformatf("arb%0d_valid", k), int'(eventValid), 1);
            check_eq($sformatf("arb%0d_btn", k), int'(eventBtn), k);
            check_eq($sformatf("arb%0d_rpt", k), int'(eventRepeat), 0);
        end
        tick(1);
        check_eq("arb_valid_post", int'(eventValid), 0);

        // Backpressure with button 1 held
        do_reset();
        eventReady = 1'b0;
        c0 = cyc;
        btnLevel[1] = 1'b0;
        tick(3);
        check_eq("bp_valid", int'(eventValid), 1);
        check_eq("bp_btn", int'(eventBtn), 1);
        check_eq("bp_pend_first", int'(pendingMask), 0);
        tick(21);
        btnLevel[1] = 1'b1;
        tick(6);
        check_eq("bp_hold_valid", int'(eventValid), 1);
        check_eq("bp_hold_btn", int'(eventBtn), 1);
        check_eq("bp_hold_rpt", int'(eventRepeat), 0);
`ifdef BTN_REPEAT_EN
        check_eq("bp_pend_merged", int'(pendingMask), 2);
        check_eq("bp_drops", drop_cnt, 3);
`else
        check_eq("bp_pend_merged", int'(pendingMask), 0);
        check_eq("bp_drops", drop_cnt, 0);
`endif
        eventReady = 1'b1;
        tick(1);
`ifdef BTN_REPEAT_EN
        check_eq("bp_next_valid", int'(eventValid), 1);
        check_eq("bp_next_btn", int'(eventBtn), 1);
        check_eq("bp_next_rpt", int'(eventRepeat), 1);
        check_eq("bp_next_pend", int'(pendingMask), 0);
        tick(1);
        check_eq("bp_drain_valid", int'(eventValid), 0);
        check_eq("bp_count", evq.size(), 2);
        check_evt("bp_acc0", 0, 30, 1, 0);
        check_evt("bp_acc1", 1, 31, 1, 1);
`else
        check_eq("bp_next_valid", int'(eventValid), 0);
        check_eq("bp_count", evq.size(), 1);
        check_evt("bp_acc0", 0, 30, 1, 0);
`endif

        // Reset while an event is stalled and button 2 is held
        do_reset();
        eventReady = 1'b0;
        c0 = cyc;
        btnLevel[2] = 1'b0;
        tick(14);
        check_eq("mid_valid_before", int'(eventValid), 1);
        reset = 1'b0;
        tick(1);
        check_eq("mid_rst_valid", int'(eventValid), 0);
        check_eq("mid_rst_btn", int'(eventBtn), 0);
        check_eq("mid_rst_rpt", int'(eventRepeat), 0);
        check_eq("mid_rst_pend", int'(pendingMask), 0);
        check_eq("mid_rst_drop", int'(eventDropped), 0);
        reset      = 1'b1;
        eventReady = 1'b1;
        evq.delete();
        c0 = cyc;
        tick(2);
        check_eq("mid_rel_valid", int'(eventValid), 0);
        check_eq("mid_rel_pend", int'(pendingMask), 4);
        tick(1);
        check_eq("mid_rel_valid2", int'(eventValid), 1);
        check_eq("mid_rel_btn", int'(eventBtn), 2);
        check_eq("mid_rel_rpt", int'(eventRepeat), 0);
        btnLevel = 4'b1111;
        tick(5);
        check_eq("mid_count", evq.size(), 1);

        // Long hold on button 3
        do_reset();
        c0 = cyc;
        btnLevel[3] = 1'b0;
        tick(40);
        btnLevel[3] = 1'b1;
        tick(10);
`ifdef BTN_REPEAT_EN
        check_eq("hold3_count", evq.size(), 9);
        check_evt("hold3_first", 0, 3, 3, 0);
        check_evt("hold3_last", 8, 41, 3, 1);
`else
        check_eq("hold3_count", evq.size(), 1);
        check_evt("hold3_first", 0, 3, 3, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
